// File: rtl/pdl_glitch_ctrl.sv
// Calibration and monitor controller for the PDL clock-glitch detector.
// Sweeps the delay tap up to the trip point, backs off by a margin, then counts alarms.
module pdl_glitch_ctrl #(
  parameter int TAP_W   = 5,
  parameter int MARGIN  = 2,
  parameter int SETTLE  = 4,
  parameter int THRESH  = 3,
  parameter int WIN_LEN = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cal_start,
  input  logic             pdl_alarm,
  input  logic             clr_alarm,
  output logic [TAP_W-1:0] tap_sel,
  output logic             cal_busy,
  output logic             cal_done,
  output logic             cal_fail,
  output logic [7:0]       glitch_cnt,
  output logic             glitch_irq,
  output logic             halt_req
);
  localparam int SET_W = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);
  localparam int WIN_W = $clog2(WIN_LEN);
  localparam logic [TAP_W-1:0] TAP_MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE, S_SETTLE, S_SAMPLE, S_BACKOFF, S_MONITOR, S_FAIL
  } state_t;

  state_t           state, next;
  logic [SET_W-1:0] set_cnt, set_cnt_nx;
  logic [TAP_W-1:0] tap_nx;
  logic [WIN_W-1:0] win_pos, win_pos_nx;
  logic [7:0]       win_cnt, win_cnt_nx, win_base, cnt_nx;
  logic             irq_nx, halt_nx;
  logic             mon, restart, wrap, hit;

  always_comb begin
    next       = state;
    set_cnt_nx = set_cnt;
    tap_nx     = tap_sel;
    case (state)
      S_IDLE, S_FAIL: begin
        if (cal_start) begin
          next       = S_SETTLE;
          tap_nx     = '0;
          set_cnt_nx = '0;
        end
      end
      S_SETTLE: begin
        if (set_cnt == SET_W'(SETTLE - 1)) begin
          next       = S_SAMPLE;
          set_cnt_nx = '0;
        end else begin
          set_cnt_nx = set_cnt + 1'b1;
        end
      end
      S_SAMPLE: begin
        if (pdl_alarm) begin
          // Tripping at or below the margin leaves no usable locked tap.
          if (int'(tap_sel) < MARGIN + 1) begin
            next   = S_FAIL;
            tap_nx = '0;
          end else begin
            next   = S_BACKOFF;
            tap_nx = tap_sel - TAP_W'(MARGIN);
          end
        end else if (tap_sel == TAP_MAX) begin
          next   = S_FAIL;
          tap_nx = '0;
        end else begin
          next   = S_SETTLE;
          tap_nx = tap_sel + 1'b1;
        end
      end
      S_BACKOFF: begin
        if (set_cnt == SET_W'(SETTLE - 1)) begin
          next       = S_MONITOR;
          set_cnt_nx = '0;
        end else begin
          set_cnt_nx = set_cnt + 1'b1;
        end
      end
      S_MONITOR: begin
        if (cal_start && !halt_req) begin
          next       = S_SETTLE;
          tap_nx     = '0;
          set_cnt_nx = '0;
        end
      end
      default: next = S_IDLE;
    endcase
  end

  always_comb begin
    mon     = (state == S_MONITOR);
    restart = mon && cal_start && !halt_req;
    wrap    = mon && (win_pos == WIN_W'(WIN_LEN - 1));
    hit     = mon && pdl_alarm;

    win_pos_nx = '0;
    if (mon && !restart && !wrap) win_pos_nx = win_pos + 1'b1;

    // Clear or wrap happens before the alarm is added, so the alarm always lands in the new count.
    win_base = (clr_alarm || wrap || restart) ? 8'd0 : win_cnt;
    win_cnt_nx = win_base;
    if (hit && !restart && win_base < 8'(THRESH)) win_cnt_nx = win_base + 8'd1;

    cnt_nx = clr_alarm ? 8'd0 : glitch_cnt;
    if (hit && cnt_nx != 8'hff) cnt_nx = cnt_nx + 8'd1;

    irq_nx  = (clr_alarm ? 1'b0 : glitch_irq) | hit;
    halt_nx = (clr_alarm ? 1'b0 : halt_req) |
              (hit && !restart && win_cnt_nx == 8'(THRESH));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      set_cnt    <= '0;
      tap_sel    <= '0;
      win_pos    <= '0;
      win_cnt    <= '0;
      glitch_cnt <= '0;
      glitch_irq <= 1'b0;
      halt_req   <= 1'b0;
      cal_busy   <= 1'b0;
      cal_done   <= 1'b0;
      cal_fail   <= 1'b0;
    end else begin
      state      <= next;
      set_cnt    <= set_cnt_nx;
      tap_sel    <= tap_nx;
      win_pos    <= win_pos_nx;
      win_cnt    <= win_cnt_nx;
      glitch_cnt <= cnt_nx;
      glitch_irq <= irq_nx;
      halt_req   <= halt_nx;
      cal_busy   <= (next == S_SETTLE) || (next == S_SAMPLE) || (next == S_BACKOFF);
      cal_done   <= (state == S_BACKOFF) && (next == S_MONITOR);
      cal_fail   <= (next == S_FAIL);
    end
  end
endmodule

// File: tb/tb_pdl_glitch_ctrl.sv
// Directed bench for pdl_glitch_ctrl: calibration timing, margin boundary, failures, monitor windows.
module tb_pdl_glitch_ctrl;
  localparam int WIN = 1024;

  logic       clk = 1'b0, rst = 1'b1, cal_start = 1'b0, clr_alarm = 1'b0, man = 1'b0;
  logic       pdl_alarm;
  logic [4:0] tap_sel;
  logic       cal_busy, cal_done, cal_fail, glitch_irq, halt_req;
  logic [7:0] glitch_cnt;
  int         mode = 0;   // 0: manual pulses, 1: trip when tap >= trip, 2: stuck high
  logic [4:0] trip = 5'd5;
  int         errors = 0, checks = 0, off = 0;

  pdl_glitch_ctrl dut (
    .clk(clk), .rst(rst), .cal_start(cal_start), .pdl_alarm(pdl_alarm),
    .clr_alarm(clr_alarm), .tap_sel(tap_sel), .cal_busy(cal_busy),
    .cal_done(cal_done), .cal_fail(cal_fail), .glitch_cnt(glitch_cnt),
    .glitch_irq(glitch_irq), .halt_req(halt_req)
  );

  always #5 clk = ~clk;
  assign pdl_alarm = (mode == 0) ? man : (mode == 1) ? (tap_sel >= trip) : 1'b1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk); #1;
    off = (off + 1) % WIN;
  endtask

  task automatic goto_off(input int o);
    while (off != o) tick();
  endtask

  task automatic alarm_at(input int o);
    goto_off(o);
    man = 1'b1; tick(); man = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    checks++; if (tap_sel !== 5'd0) begin errors++; $display("FAIL rst_tap got=%0d exp=0", tap_sel); end
    checks++; if (cal_busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", cal_busy); end
    checks++; if (cal_done !== 1'b0) begin errors++; $display("FAIL rst_done got=%b exp=0", cal_done); end
    checks++; if (cal_fail !== 1'b0) begin errors++; $display("FAIL rst_fail got=%b exp=0", cal_fail); end
    checks++; if (glitch_cnt !== 8'd0) begin errors++; $display("FAIL rst_cnt got=%0d exp=0", glitch_cnt); end
    checks++; if (glitch_irq !== 1'b0) begin errors++; $display("FAIL rst_irq got=%b exp=0", glitch_irq); end
    checks++; if (halt_req !== 1'b0) begin errors++; $display("FAIL rst_halt got=%b exp=0", halt_req); end
    man = 1'b1; tick(); man = 1'b0;
    checks++; if (glitch_cnt !== 8'd0 || glitch_irq !== 1'b0) begin errors++; $display("FAIL idle_alarm_ignored cnt=%0d irq=%b exp=0/0", glitch_cnt, glitch_irq); end
  endtask

  task automatic test_cal_success;
    mode = 1; trip = 5'd5;
    cal_start = 1'b1; tick(); cal_start = 1'b0;
    for (int i = 1; i <= 36; i++) begin
      if (i > 1) tick();
      checks++; if (cal_busy !== (i <= 34)) begin errors++; $display("FAIL cal_busy cyc=k+%0d got=%b exp=%b", i, cal_busy, (i <= 34)); end
      checks++; if (cal_done !== (i == 35)) begin errors++; $display("FAIL cal_done cyc=k+%0d got=%b exp=%b", i, cal_done, (i == 35)); end
      if (i == 30) begin checks++; if (tap_sel !== 5'd5) begin errors++; $display("FAIL trip_tap got=%0d exp=5", tap_sel); end end
      if (i == 31 || i == 35) begin checks++; if (tap_sel !== 5'd3) begin errors++; $display("FAIL lock_tap cyc=k+%0d got=%0d exp=3", i, tap_sel); end end
      if (i == 35) off = 0;
    end
    mode = 0;
  endtask

  task automatic test_monitor_thresh;
    alarm_at(10);
    checks++; if (glitch_irq !== 1'b1 || glitch_cnt !== 8'd1 || halt_req !== 1'b0) begin errors++; $display("FAIL thr_first irq=%b cnt=%0d halt=%b exp=1/1/0", glitch_irq, glitch_cnt, halt_req); end
    alarm_at(300);
    checks++; if (glitch_cnt !== 8'd2 || halt_req !== 1'b0) begin errors++; $display("FAIL thr_second cnt=%0d halt=%b exp=2/0", glitch_cnt, halt_req); end
    alarm_at(900);
    checks++; if (glitch_cnt !== 8'd3 || halt_req !== 1'b1) begin errors++; $display("FAIL thr_third cnt=%0d halt=%b exp=3/1", glitch_cnt, halt_req); end
    checks++; if (tap_sel !== 5'd3) begin errors++; $display("FAIL monitor_tap got=%0d exp=3", tap_sel); end
    clr_alarm = 1'b1; tick(); clr_alarm = 1'b0;
    checks++; if (glitch_cnt !== 8'd0 || glitch_irq !== 1'b0 || halt_req !== 1'b0) begin errors++; $display("FAIL clr cnt=%0d irq=%b halt=%b exp=0/0/0", glitch_cnt, glitch_irq, halt_req); end
  endtask

  task automatic test_window_wrap;
    alarm_at(1000); alarm_at(1020); alarm_at(5);
    checks++; if (halt_req !== 1'b0 || glitch_cnt !== 8'd3) begin errors++; $display("FAIL wrap_split halt=%b cnt=%0d exp=0/3", halt_req, glitch_cnt); end
    clr_alarm = 1'b1; tick(); clr_alarm = 1'b0;
    alarm_at(1023); alarm_at(3);
    checks++; if (halt_req !== 1'b0 || glitch_cnt !== 8'd2) begin errors++; $display("FAIL wrap_cycle_mid halt=%b cnt=%0d exp=0/2", halt_req, glitch_cnt); end
    alarm_at(7);
    checks++; if (halt_req !== 1'b1 || glitch_cnt !== 8'd3) begin errors++; $display("FAIL wrap_cycle_new halt=%b cnt=%0d exp=1/3", halt_req, glitch_cnt); end
  endtask

  task automatic test_clear_recal;
    clr_alarm = 1'b1; man = 1'b1; tick(); clr_alarm = 1'b0; man = 1'b0;
    checks++; if (glitch_cnt !== 8'd1 || glitch_irq !== 1'b1 || halt_req !== 1'b0) begin errors++; $display("FAIL clr_vs_alarm cnt=%0d irq=%b halt=%b exp=1/1/0", glitch_cnt, glitch_irq, halt_req); end
    man = 1'b1; tick(); tick(); man = 1'b0;
    checks++; if (glitch_cnt !== 8'd3 || halt_req !== 1'b1) begin errors++; $display("FAIL b2b_alarms cnt=%0d halt=%b exp=3/1", glitch_cnt, halt_req); end
    cal_start = 1'b1; tick(); cal_start = 1'b0;
    checks++; if (cal_busy !== 1'b0 || tap_sel !== 5'd3 || halt_req !== 1'b1) begin errors++; $display("FAIL start_blocked busy=%b tap=%0d halt=%b exp=0/3/1", cal_busy, tap_sel, halt_req); end
    clr_alarm = 1'b1; tick(); clr_alarm = 1'b0;
    man = 1'b1; tick(); man = 1'b0;
    checks++; if (glitch_cnt !== 8'd1 || halt_req !== 1'b0) begin errors++; $display("FAIL pre_restart cnt=%0d halt=%b exp=1/0", glitch_cnt, halt_req); end
    mode = 1; trip = 5'd5;
    cal_start = 1'b1; tick(); cal_start = 1'b0;
    checks++; if (cal_busy !== 1'b1 || tap_sel !== 5'd0) begin errors++; $display("FAIL restart busy=%b tap=%0d exp=1/0", cal_busy, tap_sel); end
    checks++; if (glitch_cnt !== 8'd1 || glitch_irq !== 1'b1) begin errors++; $display("FAIL restart_hold cnt=%0d irq=%b exp=1/1", glitch_cnt, glitch_irq); end
    // A second cal_start mid-sweep must not shift the completion cycle.
    for (int i = 2; i <= 36; i++) begin
      tick();
      cal_start = (i == 3);
      checks++; if (cal_done !== (i == 35)) begin errors++; $display("FAIL recal_done cyc=r+%0d got=%b exp=%b", i, cal_done, (i == 35)); end
      if (i == 34 || i == 35) begin checks++; if (cal_busy !== (i == 34)) begin errors++; $display("FAIL recal_busy cyc=r+%0d got=%b exp=%b", i, cal_busy, (i == 34)); end end
      if (i == 35) begin checks++; if (tap_sel !== 5'd3) begin errors++; $display("FAIL recal_tap got=%0d exp=3", tap_sel); end end
    end
    mode = 0;
    rst = 1'b1; tick(); rst = 1'b0;
    checks++; if (glitch_cnt !== 8'd0 || glitch_irq !== 1'b0 || tap_sel !== 5'd0 || cal_busy !== 1'b0) begin errors++; $display("FAIL rst_mid_monitor cnt=%0d irq=%b tap=%0d busy=%b exp=0/0/0/0", glitch_cnt, glitch_irq, tap_sel, cal_busy); end
  endtask

  task automatic test_margin_boundary;
    mode = 1; trip = 5'd2;
    cal_start = 1'b1; tick(); cal_start = 1'b0;
    for (int i = 2; i <= 16; i++) begin
      tick();
      if (i == 15) begin checks++; if (cal_fail !== 1'b0 || cal_busy !== 1'b1) begin errors++; $display("FAIL trip2_pre fail=%b busy=%b exp=0/1", cal_fail, cal_busy); end end
      if (i == 16) begin checks++; if (cal_fail !== 1'b1 || cal_busy !== 1'b0 || tap_sel !== 5'd0) begin errors++; $display("FAIL trip2_fail fail=%b busy=%b tap=%0d exp=1/0/0", cal_fail, cal_busy, tap_sel); end end
    end
    trip = 5'd3;
    cal_start = 1'b1; tick(); cal_start = 1'b0;
    checks++; if (cal_fail !== 1'b0) begin errors++; $display("FAIL fail_cleared got=%b exp=0", cal_fail); end
    for (int i = 2; i <= 25; i++) begin
      tick();
      if (i == 24) begin checks++; if (cal_done !== 1'b0) begin errors++; $display("FAIL trip3_early_done got=%b exp=0", cal_done); end end
      if (i == 25) begin checks++; if (cal_done !== 1'b1 || tap_sel !== 5'd1) begin errors++; $display("FAIL trip3_lock done=%b tap=%0d exp=1/1", cal_done, tap_sel); end end
    end
    rst = 1'b1; tick(); rst = 1'b0;
  endtask

  task automatic test_early_trip;
    mode = 2;
    cal_start = 1'b1; tick(); cal_start = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      if (i > 1) tick();
      checks++; if (cal_fail !== (i >= 6) || cal_done !== 1'b0) begin errors++; $display("FAIL early_trip cyc=k+%0d fail=%b done=%b exp=%b/0", i, cal_fail, cal_done, (i >= 6)); end
      if (i == 6) begin checks++; if (tap_sel !== 5'd0) begin errors++; $display("FAIL early_tap got=%0d exp=0", tap_sel); end end
    end
    checks++; if (glitch_cnt !== 8'd0 || glitch_irq !== 1'b0) begin errors++; $display("FAIL fail_alarm_ignored cnt=%0d irq=%b exp=0/0", glitch_cnt, glitch_irq); end
    mode = 0;
  endtask

  task automatic test_no_trip;
    man = 1'b0;
    cal_start = 1'b1; tick(); cal_start = 1'b0;
    checks++; if (cal_fail !== 1'b0 || cal_busy !== 1'b1) begin errors++; $display("FAIL notrip_start fail=%b busy=%b exp=0/1", cal_fail, cal_busy); end
    for (int i = 2; i <= 162; i++) begin
      tick();
      if (i == 160) begin checks++; if (tap_sel !== 5'd31 || cal_fail !== 1'b0) begin errors++; $display("FAIL notrip_last tap=%0d fail=%b exp=31/0", tap_sel, cal_fail); end end
      if (i == 161) begin checks++; if (cal_fail !== 1'b1 || tap_sel !== 5'd0 || cal_busy !== 1'b0) begin errors++; $display("FAIL notrip_fail fail=%b tap=%0d busy=%b exp=1/0/0", cal_fail, tap_sel, cal_busy); end end
    end
  endtask

  initial begin
    test_reset();
    test_cal_success();
    test_monitor_thresh();
    test_window_wrap();
    test_clear_recal();
    test_margin_boundary();
    test_early_trip();
    test_no_trip();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
